sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering data between blocks in one clock domain, such as the SDRAM controller's request and read-return paths, where the dual-clock FIFO's pointer synchroniser adds latency and area for no benefit. It adds features the dual-clock FIFO lacks:
- exact occupancy count;
- run-time programmable almost-full and almost-empty thresholds;
- synchronous flush;
- sticky overflow and underflow flags with clear.

Show-ahead and registered read modes are selected by a parameter.

---
 rtl/sync_fifo.sv | 103 ++++++++++
 tb/tb_sync_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with exact occupancy count, programmable almost flags, flush and sticky errors
// Ports: clk/reset_n (async active-low), flush (sync clear), wr_en/wr_data write side,
//        rd_en/rd_data/rd_valid read side (show-ahead when RD_FAST=1, registered when 0),
//        afull_thr/aempty_thr thresholds, err_clr clears ovf/udf,
//        count/full/empty/afull/aempty status, ovf/udf sticky error flags.
module sync_fifo #(
    parameter int W       = 8,
    parameter int DP      = 8,
    parameter int AW      = $clog2(DP),
    parameter int RD_FAST = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    input  logic [AW:0]   afull_thr,
    input  logic [AW:0]   aempty_thr,
    input  logic          err_clr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic          ovf,
    output logic          udf
);
    if (DP < 2 || DP > 256 || (DP & (DP - 1)) != 0) begin : g_bad_dp
        $error("sync_fifo: DP must be a power of two from 2 to 256");
    end

    localparam logic [AW:0] DP_CNT = (AW+1)'(DP);

    logic [W-1:0]  mem_q [DP];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_acc, rd_acc;

    assign count  = count_q;
    assign full   = count_q == DP_CNT;
    assign empty  = count_q == '0;
    assign afull  = count_q >= afull_thr;
    assign aempty = count_q <= aempty_thr;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    // Acceptance looks only at the registered count, so a same-cycle read never frees room for a write
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_acc);
        count_d  = flush ? '0 : count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        // A new error event outranks a simultaneous clear
        ovf_d    = (wr_en & full & ~flush) | (ovf_q & ~err_clr);
        udf_d    = (rd_en & empty & ~flush) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    if (RD_FAST != 0) begin : g_fast
        assign rd_data  = mem_q[rd_ptr_q];
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [W-1:0] rd_data_q, rd_data_d;
        logic         rd_valid_q;
        assign rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
        assign rd_data   = rd_data_q;
        assign rd_valid  = rd_valid_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_acc;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: random and directed stimulus on show-ahead and registered FIFOs against a queue model
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       reset_n, flush, wr_en, rd_en, err_clr;
    logic [7:0] wr_data;
    logic [3:0] afull_thr, aempty_thr;
    logic [7:0] rd_data_f, rd_data_r;
    logic       rd_valid_f, rd_valid_r;
    logic [3:0] count_f, count_r;
    logic       full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
    logic       full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;

    logic [7:0] q[$];
    logic       ovf_m, udf_m, rv_m;
    logic [7:0] rd_m;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.W(8), .DP(8), .RD_FAST(1)) u_fast (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_f), .rd_valid(rd_valid_f),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .err_clr(err_clr),
        .count(count_f), .full(full_f), .empty(empty_f), .afull(afull_f), .aempty(aempty_f),
        .ovf(ovf_f), .udf(udf_f)
    );

    sync_fifo #(.W(8), .DP(8), .RD_FAST(0)) u_reg (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_r), .rd_valid(rd_valid_r),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .err_clr(err_clr),
        .count(count_r), .full(full_r), .empty(empty_r), .afull(afull_r), .aempty(aempty_r),
        .ovf(ovf_r), .udf(udf_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count_f", 32'(count_f), n);
        chk("count_r", 32'(count_r), n);
        chk("full", {full_f, full_r}, {2{n == 8}});
        chk("empty", {empty_f, empty_r}, {2{n == 0}});
        chk("afull", {afull_f, afull_r}, {2{n >= int'(afull_thr)}});
        chk("aempty", {aempty_f, aempty_r}, {2{n <= int'(aempty_thr)}});
        chk("ovf", {ovf_f, ovf_r}, {2{ovf_m}});
        chk("udf", {udf_f, udf_r}, {2{udf_m}});
        chk("rd_valid_f", 32'(rd_valid_f), n > 0);
        if (n > 0) chk("rd_data_f", 32'(rd_data_f), 32'(q[0]));
        chk("rd_valid_r", 32'(rd_valid_r), 32'(rv_m));
        chk("rd_data_r", 32'(rd_data_r), 32'(rd_m));
    endtask

    function automatic void model_reset();
        q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rv_m  = 1'b0;
        rd_m  = 8'h00;
    endfunction

    function automatic void model_step();
        int n;
        n = q.size();
        ovf_m = (wr_en && n == 8 && !flush) || (ovf_m && !err_clr);
        udf_m = (rd_en && n == 0 && !flush) || (udf_m && !err_clr);
        rv_m  = 1'b0;
        if (flush) q.delete();
        else begin
            if (rd_en && n > 0) begin
                rd_m = q.pop_front();
                rv_m = 1'b1;
            end
            if (wr_en && n < 8) q.push_back(wr_data);
        end
    endfunction

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f, input logic ec);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        err_clr = ec;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {flush, wr_en, rd_en, err_clr} = '0;
        wr_data    = 8'h00;
        afull_thr  = 4'd0;
        aempty_thr = 4'd0;
        model_reset();
        #3 check_all();
        @(posedge clk);
        #1 reset_n = 1'b1;
        afull_thr  = 4'd6;
        aempty_thr = 4'd1;
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'hFF, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
        cyc(1, 8'h11, 1, 0, 0);
        cyc(1, 8'h22, 0, 0, 1);
        cyc(1, 8'h33, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), 1, 0, 0);
        while (q.size() < 8) cyc(1, 8'($urandom), 0, 0, 0);
        cyc(1, 8'hEE, 1, 0, 0);
        cyc(1, 8'hDD, 0, 0, 0);
        cyc(1, 8'hCC, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(1, 8'h77, 1, 1, 0);
        cyc(1, 8'h99, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(1, 8'hA5, 0, 0, 0);
        cyc(1, 8'h5A, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), i[0], 0, 0);
        cyc(1, 8'h00, 1, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int s = 0; s < 20; s++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            afull_thr  = 4'($urandom_range(0, 15));
            aempty_thr = 4'($urandom_range(0, 15));
            for (int i = 0; i < 80; i++)
                cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        end
        cyc(0, 8'h00, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
